// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard
// Description : Tracks in-flight register writes from EX to WB and derives the
//               issue stall and per-operand forwarding selects.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard #(
    parameter  int NUM_REGS   = 16,
    parameter  int DEPTH      = 4,
    parameter  int LOAD_READY = 3,
    localparam int REG_W      = $clog2(NUM_REGS),
    localparam int SEL_W      = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    input  logic [REG_W-1:0]    id_rs1,
    input  logic [REG_W-1:0]    id_rs2,
    input  logic                id_rs1_used,
    input  logic                id_rs2_used,
    input  logic [REG_W-1:0]    id_rd,
    input  logic                id_we,
    input  logic                id_is_load,
    input  logic                flush,
    output logic                stall,
    output logic [SEL_W-1:0]    fwd_sel_rs1,
    output logic [SEL_W-1:0]    fwd_sel_rs2,
    output logic [NUM_REGS-1:0] pending_mask,
    output logic [31:0]         stall_cycles
);

    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] r_we;
    logic [DEPTH-1:0] r_load;
    logic [REG_W-1:0] r_rd [DEPTH];
    logic [31:0]      r_stall_cnt;

    logic [SEL_W:0]   w_res_rs1;
    logic [SEL_W:0]   w_res_rs2;
    logic             w_issue;

    // Scans oldest to youngest so the youngest matching stage wins.
    // Result is {hazard, select}.
    function automatic logic [SEL_W:0] resolve(input logic [REG_W-1:0] src,
                                               input logic             used);
        logic [SEL_W:0] res;
        res = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (used && (src != '0) && r_valid[k] && r_we[k] && (r_rd[k] == src)) begin
                if (!r_load[k] || (k >= LOAD_READY))
                    res = {1'b0, SEL_W'(k + 1)};
                else
                    res = {1'b1, {SEL_W{1'b0}}};
            end
        end
        return res;
    endfunction

    always_comb begin
        w_res_rs1 = resolve(id_rs1, id_rs1_used);
        w_res_rs2 = resolve(id_rs2, id_rs2_used);
    end

    assign stall       = ~flush & (w_res_rs1[SEL_W] | w_res_rs2[SEL_W]);
    assign fwd_sel_rs1 = w_res_rs1[SEL_W-1:0];
    assign fwd_sel_rs2 = w_res_rs2[SEL_W-1:0];
    assign w_issue     = id_valid & ~stall & ~flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid     <= '0;
            r_we        <= '0;
            r_load      <= '0;
            r_stall_cnt <= '0;
            for (int k = 0; k < DEPTH; k++)
                r_rd[k] <= '0;
        end else begin
            // Stages always advance; a stall only swaps the issue for a bubble.
            for (int k = DEPTH - 1; k > 0; k--) begin
                r_valid[k] <= r_valid[k-1];
                r_we[k]    <= r_we[k-1];
                r_load[k]  <= r_load[k-1];
                r_rd[k]    <= r_rd[k-1];
            end
            r_valid[0] <= w_issue;
            r_we[0]    <= id_we;
            r_load[0]  <= id_is_load;
            r_rd[0]    <= id_rd;
            if (stall && (r_stall_cnt != 32'hFFFF_FFFF))
                r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cnt;

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_mask
        logic [DEPTH-1:0] w_hit;
        for (genvar k = 0; k < DEPTH; k++) begin : g_stage
            assign w_hit[k] = r_valid[k] & r_we[k] & (r_rd[k] == REG_W'(r));
        end
        if (r == 0) begin : g_zero
            assign pending_mask[r] = 1'b0;
        end else begin : g_reg
            assign pending_mask[r] = |w_hit;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_scoreboard
// Description : Directed self-checking bench for hazard_scoreboard (defaults).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [3:0]  id_rs1;
    logic [3:0]  id_rs2;
    logic        id_rs1_used;
    logic        id_rs2_used;
    logic [3:0]  id_rd;
    logic        id_we;
    logic        id_is_load;
    logic        flush;
    logic        stall;
    logic [2:0]  fwd_sel_rs1;
    logic [2:0]  fwd_sel_rs2;
    logic [15:0] pending_mask;
    logic [31:0] stall_cycles;

    int n_checks = 0;
    int n_pass   = 0;

    hazard_scoreboard dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rs1_used  (id_rs1_used),
        .id_rs2_used  (id_rs2_used),
        .id_rd        (id_rd),
        .id_we        (id_we),
        .id_is_load   (id_is_load),
        .flush        (flush),
        .stall        (stall),
        .fwd_sel_rs1  (fwd_sel_rs1),
        .fwd_sel_rs2  (fwd_sel_rs2),
        .pending_mask (pending_mask),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Drive an ID instruction and let combinational outputs settle.
    task automatic drive(input logic v, input logic [3:0] rs1, input logic u1,
                         input logic [3:0] rs2, input logic u2,
                         input logic [3:0] rd, input logic we, input logic ld);
        id_valid    = v;
        id_rs1      = rs1;
        id_rs1_used = u1;
        id_rs2      = rs2;
        id_rs2_used = u2;
        id_rd       = rd;
        id_we       = we;
        id_is_load  = ld;
        #1;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        repeat (n) cyc();
    endtask

    initial begin
        rst   = 1'b1;
        flush = 1'b0;
        drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        repeat (2) cyc();
        rst = 1'b0;
        #1;
        chk("reset_stall", {31'd0, stall}, 32'd0);
        chk("reset_sel1",  {29'd0, fwd_sel_rs1}, 32'd0);
        chk("reset_mask",  {16'd0, pending_mask}, 32'd0);
        chk("reset_cnt",   stall_cycles, 32'd0);

        // ALU rd=5, then an unrelated read of x3
        drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1, 1'b0);
        cyc();
        drive(1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        chk("unrel_stall", {31'd0, stall}, 32'd0);
        chk("unrel_sel1",  {29'd0, fwd_sel_rs1}, 32'd0);
        chk("unrel_mask",  {16'd0, pending_mask}, 32'h0020);
        cyc();
        idle(4);
        chk("drain_mask",  {16'd0, pending_mask}, 32'd0);

        // ALU back-to-back, then with one bubble between
        drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1, 1'b0);
        cyc();
        drive(1'b1, 4'd5, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        chk("b2b_stall", {31'd0, stall}, 32'd0);
        chk("b2b_sel1",  {29'd0, fwd_sel_rs1}, 32'd1);
        cyc();
        idle(4);
        drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1, 1'b0);
        cyc();
        idle(1);
        drive(1'b1, 4'd5, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        chk("gap_sel1",  {29'd0, fwd_sel_rs1}, 32'd2);
        cyc();
        idle(4);

        // Load-use: three stall cycles, then forward from WB
        drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd6, 1'b1, 1'b1);
        cyc();
        drive(1'b1, 4'd0, 1'b0, 4'd6, 1'b1, 4'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("lu_stall%0d", i), {31'd0, stall}, 32'd1);
            cyc();
        end
        chk("lu_stall_end", {31'd0, stall}, 32'd0);
        chk("lu_sel2",      {29'd0, fwd_sel_rs2}, 32'd4);
        chk("lu_cnt",       stall_cycles, 32'd3);
        cyc();
        idle(4);

        // Youngest of two writers wins
        drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd7, 1'b1, 1'b0);
        cyc();
        idle(1);
        drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd7, 1'b1, 1'b0);
        cyc();
        drive(1'b1, 4'd7, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        chk("young_sel1", {29'd0, fwd_sel_rs1}, 32'd1);
        cyc();
        idle(4);

        // x0 never tracked
        drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0);
        cyc();
        drive(1'b1, 4'd0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        chk("x0_sel1",  {29'd0, fwd_sel_rs1}, 32'd0);
        chk("x0_stall", {31'd0, stall}, 32'd0);
        chk("x0_mask",  {16'd0, pending_mask}, 32'd0);
        cyc();
        idle(4);

        // Unused operand does not stall; the same operand used does
        drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd6, 1'b1, 1'b1);
        cyc();
        drive(1'b1, 4'd0, 1'b0, 4'd6, 1'b0, 4'd9, 1'b1, 1'b0);
        chk("unused_stall", {31'd0, stall}, 32'd0);
        chk("unused_sel2",  {29'd0, fwd_sel_rs2}, 32'd0);
        drive(1'b1, 4'd0, 1'b0, 4'd6, 1'b1, 4'd9, 1'b1, 1'b0);
        chk("used_stall",   {31'd0, stall}, 32'd1);

        // Flush during a load-use hazard: bubble in, counter frozen
        flush = 1'b1;
        #1;
        chk("flush_stall", {31'd0, stall}, 32'd0);
        cyc();
        flush = 1'b0;
        #1;
        chk("flush_cnt",   stall_cycles, 32'd3);
        chk("flush_mask",  {16'd0, pending_mask}, 32'h0040);
        chk("post_flush_stall", {31'd0, stall}, 32'd1);
        cyc();
        chk("pre_rst_cnt", stall_cycles, 32'd4);

        // Reset mid-stall drops all tracking
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        chk("rst_mask",  {16'd0, pending_mask}, 32'd0);
        chk("rst_cnt",   stall_cycles, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
